io_timer: RTL and testbench



---
 rtl/io_timer.sv | 247 ++++++++++++++++++++++++
 tb/tb_io_timer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_timer.sv
// io_timer: memory-mapped prescaled 32-bit timer with compare match, sticky status and level irq.
// Latency: reads are combinational (same cycle); writes take effect at the next rising clk edge.
// Backpressure: none; every io access completes in the cycle it is presented.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   io_address               byte address; window selected by io_address[31:5] == BASE_ADDR[31:5]
//   io_write_value           store data, right-aligned (byte in [7:0], half in [15:0])
//   io_write_en, io_read_en  store / load strobes
//   io_data_size             funct3 size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   io_read_value            load data, 0 when not selected or not reading (OR-able)
//   irq                      STATUS.match & CTRL.irq_en, level
//
// Optional feature macro: IO_TIMER_ONESHOT_EN adds CTRL[3] oneshot (a match clears CTRL.en).
// Without it CTRL[3] reads 0, ignores writes and the timer free-runs.
//
// Register map (offset = io_address[4:2]):
//   0x00 CTRL [0] en [1] auto_reload [2] irq_en [3] oneshot (optional)
//   0x04 PRESCALE [PRESCALE_W-1:0]   0x08 COUNT   0x0C COMPARE
//   0x10 STATUS [0] match (sticky, W1C)   0x14-0x1C reserved (read 0)

module io_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           io_address,
    input  logic [31:0]           io_write_value,
    output logic [31:0]           io_read_value,
    input  logic                  io_write_en,
    input  logic                  io_read_en,
    input  logic [2:0]            io_data_size,
    output logic                  irq
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // State
    logic                  ctrl_en_q,     ctrl_en_d;
    logic                  ctrl_ar_q,     ctrl_ar_d;
    logic                  ctrl_irq_en_q, ctrl_irq_en_d;
    logic [PRESCALE_W-1:0] prescale_q,    prescale_d;
    logic [PRESCALE_W-1:0] pre_cnt_q,     pre_cnt_d;
    logic [31:0]           count_q,       count_d;
    logic [31:0]           compare_q,     compare_d;
    logic                  match_q,       match_d;
    logic                  ctrl_os;

`ifdef IO_TIMER_ONESHOT_EN
    logic                  ctrl_os_q,     ctrl_os_d;
    assign ctrl_os = ctrl_os_q;
`else
    assign ctrl_os = 1'b0;
`endif

    // Address decode
    logic        sel;
    logic [2:0]  reg_off;
    logic [1:0]  lane;

    assign sel     = (io_address[31:5] == BASE_ADDR[31:5]);
    assign reg_off = io_address[4:2];
    assign lane    = io_address[1:0];

    // Store lane enables and lane-replicated data. Misaligned H/W and
    // reserved size codes produce no lane enables, so the store vanishes.
    logic [3:0]  wr_be;
    logic [31:0] wr_dat;
    logic [31:0] wr_mask;

    always_comb begin
        wr_be  = 4'b0000;
        wr_dat = io_write_value;
        case (io_data_size)
            SZ_B: begin
                wr_be  = 4'b0001 << lane;
                wr_dat = {4{io_write_value[7:0]}};
            end
            SZ_H: begin
                wr_dat = {2{io_write_value[15:0]}};
                if (!lane[0]) begin
                    wr_be = lane[1] ? 4'b1100 : 4'b0011;
                end
            end
            SZ_W: begin
                if (lane == 2'b00) begin
                    wr_be = 4'b1111;
                end
            end
            default: wr_be = 4'b0000;
        endcase
        if (!(io_write_en && sel)) begin
            wr_be = 4'b0000;
        end
        wr_mask = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
    end

    logic wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;

    assign wr_ctrl     = (reg_off == OFF_CTRL)     && (wr_be != 4'b0000);
    assign wr_prescale = (reg_off == OFF_PRESCALE) && (wr_be != 4'b0000);
    assign wr_count    = (reg_off == OFF_COUNT)    && (wr_be != 4'b0000);
    assign wr_compare  = (reg_off == OFF_COMPARE)  && (wr_be != 4'b0000);
    assign wr_status   = (reg_off == OFF_STATUS)   && (wr_be != 4'b0000);

    // Prescaler and counter next state
    logic tick;
    logic match_hit;

    assign tick      = ctrl_en_q && (pre_cnt_q == prescale_q);
    assign match_hit = tick && (count_q == compare_q);

    always_comb begin
        ctrl_en_d     = ctrl_en_q;
        ctrl_ar_d     = ctrl_ar_q;
        ctrl_irq_en_d = ctrl_irq_en_q;
`ifdef IO_TIMER_ONESHOT_EN
        ctrl_os_d     = ctrl_os_q;
`endif
        prescale_d    = prescale_q;
        pre_cnt_d     = pre_cnt_q + PRESCALE_W'(1);
        count_d       = count_q;
        compare_d     = compare_q;
        match_d       = match_q;

        // CTRL bits all live in lane 0
        if (wr_ctrl && wr_be[0]) begin
            ctrl_en_d     = wr_dat[0];
            ctrl_ar_d     = wr_dat[1];
            ctrl_irq_en_d = wr_dat[2];
`ifdef IO_TIMER_ONESHOT_EN
            ctrl_os_d     = wr_dat[3];
`endif
        end

        if (wr_prescale) begin
            prescale_d = (prescale_q & ~wr_mask[PRESCALE_W-1:0])
                       | (wr_dat[PRESCALE_W-1:0] & wr_mask[PRESCALE_W-1:0]);
        end

        // Any CTRL/PRESCALE store restarts the prescale period.
        if (wr_ctrl || wr_prescale || !ctrl_en_q || tick) begin
            pre_cnt_d = '0;
        end

        if (tick) begin
            count_d = (match_hit && ctrl_ar_q) ? 32'd0 : count_q + 32'd1;
        end
        // Software store to COUNT overrides a same-cycle increment.
        if (wr_count) begin
            count_d = (count_q & ~wr_mask) | (wr_dat & wr_mask);
        end

        if (wr_compare) begin
            compare_d = (compare_q & ~wr_mask) | (wr_dat & wr_mask);
        end

        // W1C first so a simultaneous match re-sets the flag.
        if (wr_status && wr_be[0] && wr_dat[0]) begin
            match_d = 1'b0;
        end
        if (match_hit) begin
            match_d = 1'b1;
        end

        // Oneshot: stop the timer at its post-match value.
        if (match_hit && ctrl_os) begin
            ctrl_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en_q     <= 1'b0;
            ctrl_ar_q     <= 1'b0;
            ctrl_irq_en_q <= 1'b0;
            prescale_q    <= '0;
            pre_cnt_q     <= '0;
            count_q       <= 32'd0;
            compare_q     <= 32'd0;
            match_q       <= 1'b0;
        end else begin
            ctrl_en_q     <= ctrl_en_d;
            ctrl_ar_q     <= ctrl_ar_d;
            ctrl_irq_en_q <= ctrl_irq_en_d;
            prescale_q    <= prescale_d;
            pre_cnt_q     <= pre_cnt_d;
            count_q       <= count_d;
            compare_q     <= compare_d;
            match_q       <= match_d;
        end
    end

`ifdef IO_TIMER_ONESHOT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_os_q <= 1'b0;
        end else begin
            ctrl_os_q <= ctrl_os_d;
        end
    end
`endif

    // Read path
    logic [31:0] rd_word;
    logic [31:0] rd_shift;

    always_comb begin
        rd_word = 32'd0;
        case (reg_off)
            OFF_CTRL:     rd_word = {28'd0, ctrl_os, ctrl_irq_en_q, ctrl_ar_q, ctrl_en_q};
            OFF_PRESCALE: rd_word = 32'(prescale_q);
            OFF_COUNT:    rd_word = count_q;
            OFF_COMPARE:  rd_word = compare_q;
            OFF_STATUS:   rd_word = {31'd0, match_q};
            default:      rd_word = 32'd0;
        endcase

        rd_shift = rd_word >> {lane, 3'b000};

        io_read_value = 32'd0;
        if (io_read_en && sel) begin
            case (io_data_size)
                SZ_B:    io_read_value = {{24{rd_shift[7]}}, rd_shift[7:0]};
                SZ_H:    io_read_value = {{16{rd_shift[15]}}, rd_shift[15:0]};
                SZ_W:    io_read_value = rd_shift;
                SZ_BU:   io_read_value = {24'd0, rd_shift[7:0]};
                SZ_HU:   io_read_value = {16'd0, rd_shift[15:0]};
                default: io_read_value = 32'd0;
            endcase
        end
    end

    assign irq = match_q & ctrl_irq_en_q;

endmodule

// File: tb/tb_io_timer.sv
module tb_io_timer;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_PRE  = BASE + 32'h04;
    localparam logic [31:0] A_CNT  = BASE + 32'h08;
    localparam logic [31:0] A_CMP  = BASE + 32'h0C;
    localparam logic [31:0] A_STAT = BASE + 32'h10;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

`ifdef IO_TIMER_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] io_address;
    logic [31:0] io_write_value;
    logic [31:0] io_read_value;
    logic        io_write_en;
    logic        io_read_en;
    logic [2:0]  io_data_size;
    logic        irq;

    int checks;
    int failures;

    io_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .io_address     (io_address),
        .io_write_value (io_write_value),
        .io_read_value  (io_read_value),
        .io_write_en    (io_write_en),
        .io_read_en     (io_read_en),
        .io_data_size   (io_data_size),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  size;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(bit wr, logic [31:0] addr, logic [31:0] data,
                                    logic [2:0] size, logic [31:0] exp, string name);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.size = size; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
        @(negedge clk);
        io_address     = a;
        io_write_value = d;
        io_data_size   = sz;
        io_write_en    = 1'b1;
        @(posedge clk);
        #1;
        io_write_en    = 1'b0;
    endtask

    task automatic read_now(input logic [31:0] a, input logic [2:0] sz, output logic [31:0] v);
        io_address   = a;
        io_data_size = sz;
        io_read_en   = 1'b1;
        #1;
        v = io_read_value;
        io_read_en   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] rv;

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        io_address = 32'd0; io_write_value = 32'd0;
        io_write_en = 1'b0; io_read_en = 1'b0; io_data_size = SZ_W;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state of every offset in the window
        for (int i = 0; i < 8; i++) begin
            read_now(BASE + 32'(i * 4), SZ_W, rv);
            check($sformatf("reset_off_%0d", i * 4), rv, 32'd0);
        end
        check("reset_irq", {31'd0, irq}, 32'd0);

        // Register access table (timer disabled throughout)
        add_vec(1, A_CMP,              32'h80FF_1234, SZ_W,  32'h0,          "sw_compare");
        add_vec(0, A_CMP,              32'h0,         SZ_W,  32'h80FF_1234,  "lw_compare");
        add_vec(0, A_CMP + 1,          32'h0,         SZ_B,  32'h0000_0012,  "lb_plus1");
        add_vec(0, A_CMP + 3,          32'h0,         SZ_BU, 32'h0000_0080,  "lbu_plus3");
        add_vec(0, A_CMP + 3,          32'h0,         SZ_B,  32'hFFFF_FF80,  "lb_plus3_sext");
        add_vec(0, A_CMP + 2,          32'h0,         SZ_H,  32'hFFFF_80FF,  "lh_plus2");
        add_vec(0, A_CMP + 2,          32'h0,         SZ_HU, 32'h0000_80FF,  "lhu_plus2");
        add_vec(1, A_CMP,              32'h0000_00AA, SZ_B,  32'h0,          "sb_plus0");
        add_vec(0, A_CMP,              32'h0,         SZ_W,  32'h80FF_12AA,  "after_sb");
        add_vec(0, A_CMP,              32'h0,         SZ_B,  32'hFFFF_FFAA,  "lb_plus0_sext");
        add_vec(1, A_CMP + 1,          32'h0000_5555, SZ_H,  32'h0,          "sh_misaligned");
        add_vec(0, A_CMP,              32'h0,         SZ_W,  32'h80FF_12AA,  "after_sh_mis");
        add_vec(1, A_CMP + 2,          32'h0000_BEEF, SZ_H,  32'h0,          "sh_plus2");
        add_vec(0, A_CMP,              32'h0,         SZ_W,  32'hBEEF_12AA,  "after_sh");
        add_vec(1, A_CMP + 2,          32'h0,         SZ_W,  32'h0,          "sw_misaligned");
        add_vec(0, A_CMP,              32'h0,         SZ_W,  32'hBEEF_12AA,  "after_sw_mis");
        add_vec(1, A_CMP,              32'h0,         3'b011, 32'h0,         "sw_reserved_size");
        add_vec(0, A_CMP,              32'h0,         SZ_W,  32'hBEEF_12AA,  "after_reserved");
        add_vec(1, A_CMP + 32'h20,     32'h0,         SZ_W,  32'h0,          "sw_outside");
        add_vec(0, A_CMP,              32'h0,         SZ_W,  32'hBEEF_12AA,  "after_outside");
        add_vec(0, A_CMP + 32'h20,     32'h0,         SZ_W,  32'h0,          "lw_outside");
        add_vec(1, A_PRE,              32'hFFFF_ABCD, SZ_W,  32'h0,          "sw_prescale");
        add_vec(0, A_PRE,              32'h0,         SZ_W,  32'h0000_ABCD,  "lw_prescale");
        add_vec(1, A_CTRL,             32'hFFFF_FFF0, SZ_W,  32'h0,          "sw_ctrl_hi");
        add_vec(0, A_CTRL,             32'h0,         SZ_W,  32'h0,          "lw_ctrl_hi");
        add_vec(1, A_CTRL,             32'h0000_0008, SZ_W,  32'h0,          "sw_ctrl_os");
        add_vec(0, A_CTRL,             32'h0,         SZ_W,  ONESHOT ? 32'h8 : 32'h0, "lw_ctrl_os");
        add_vec(1, A_CTRL,             32'h0,         SZ_W,  32'h0,          "sw_ctrl_0");
        add_vec(1, BASE + 32'h18,      32'hFFFF_FFFF, SZ_W,  32'h0,          "sw_reserved_reg");
        add_vec(0, BASE + 32'h18,      32'h0,         SZ_W,  32'h0,          "lw_reserved_reg");
        add_vec(0, A_CNT,              32'h0,         SZ_B,  32'h0,          "lb_count");

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data, vecs[i].size);
            end else begin
                @(negedge clk);
                read_now(vecs[i].addr, vecs[i].size, rv);
                check(vecs[i].name, rv, vecs[i].exp);
            end
        end

        // Selected address but no read strobe
        @(negedge clk);
        io_address = A_CMP; io_data_size = SZ_W; io_read_en = 1'b0;
        #1;
        check("no_read_en", io_read_value, 32'd0);

        // Asynchronous reset mid-count
        do_reset();
        bus_write(A_CTRL, 32'h5, SZ_W);
        repeat (5) @(posedge clk);
        #1;
        read_now(A_CNT, SZ_W, rv);
        check("midcount_count", rv, 32'd5);
        check("midcount_irq", {31'd0, irq}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_irq_async", {31'd0, irq}, 32'd0);
        read_now(A_CNT, SZ_W, rv);
        check("rst_count", rv, 32'd0);
        read_now(A_STAT, SZ_W, rv);
        check("rst_status", rv, 32'd0);
        read_now(A_CTRL, SZ_W, rv);
        check("rst_ctrl", rv, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic count: prescale 3, compare 2, auto-reload, irq
        do_reset();
        bus_write(A_PRE, 32'd3, SZ_W);
        bus_write(A_CMP, 32'd2, SZ_W);
        bus_write(A_CTRL, 32'h7, SZ_W);
        repeat (11) @(posedge clk);
        #1;
        read_now(A_STAT, SZ_W, rv);
        check("basic_no_match_11", rv, 32'd0);
        @(posedge clk);
        #1;
        read_now(A_STAT, SZ_W, rv);
        check("basic_match_12", rv, 32'd1);
        check("basic_irq", {31'd0, irq}, 32'd1);
        read_now(A_CNT, SZ_W, rv);
        check("basic_reload", rv, 32'd0);
        bus_write(A_STAT, 32'd1, SZ_W);
        check("basic_irq_clear", {31'd0, irq}, 32'd0);
        read_now(A_STAT, SZ_W, rv);
        check("basic_status_clear", rv, 32'd0);

        // Collisions: W1C vs match set, COUNT store vs tick
        do_reset();
        bus_write(A_CMP, 32'd3, SZ_W);
        bus_write(A_CTRL, 32'h1, SZ_W);
        repeat (3) @(posedge clk);
        bus_write(A_STAT, 32'd1, SZ_W);
        read_now(A_STAT, SZ_W, rv);
        check("w1c_vs_set", rv, 32'd1);
        read_now(A_CNT, SZ_W, rv);
        check("count_after_match", rv, 32'd4);
        bus_write(A_CNT, 32'd100, SZ_W);
        read_now(A_CNT, SZ_W, rv);
        check("count_write_wins", rv, 32'd100);
        bus_write(A_STAT, 32'd1, SZ_W);
        read_now(A_STAT, SZ_W, rv);
        check("w1c_alone", rv, 32'd0);

        // Wrap at 0xFFFF_FFFF without a flag, then match on the next tick
        do_reset();
        bus_write(A_CNT, 32'hFFFF_FFFF, SZ_W);
        bus_write(A_CTRL, 32'h1, SZ_W);
        @(posedge clk);
        #1;
        read_now(A_CNT, SZ_W, rv);
        check("wrap_count", rv, 32'd0);
        read_now(A_STAT, SZ_W, rv);
        check("wrap_no_match", rv, 32'd0);
        @(posedge clk);
        #1;
        read_now(A_STAT, SZ_W, rv);
        check("wrap_then_match", rv, 32'd1);
        read_now(A_CNT, SZ_W, rv);
        check("wrap_then_count", rv, 32'd1);

        // Oneshot (or free-run when the feature is absent)
        do_reset();
        bus_write(A_CMP, 32'd4, SZ_W);
        bus_write(A_CTRL, 32'hD, SZ_W);
        repeat (5) @(posedge clk);
        #1;
        read_now(A_STAT, SZ_W, rv);
        check("os_match", rv, 32'd1);
        check("os_irq", {31'd0, irq}, 32'd1);
        read_now(A_CTRL, SZ_W, rv);
        check("os_ctrl", rv, ONESHOT ? 32'hC : 32'h5);
        read_now(A_CNT, SZ_W, rv);
        check("os_count", rv, 32'd5);
        repeat (3) @(posedge clk);
        #1;
        read_now(A_CNT, SZ_W, rv);
        check("os_count_later", rv, ONESHOT ? 32'd5 : 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
